// File: rtl/seq_shift_add_mul_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// One carry-lookahead add per iteration: ACC + M feeds a 9-bit sum whose
// carry shifts down into the accumulator, so no carry is ever lost.
// Eight iterations per product; valid/ready handshake on both sides.
module seq_shift_add_mul_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  generate
    if (WIDTH != 8) begin : g_width_chk
      $error("seq_shift_add_mul_8bit: WIDTH must be 8");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_cnt_chk
      $error("seq_shift_add_mul_8bit: CNT_W too narrow for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Carry-lookahead adder: every carry is formed directly from the
  // generate/propagate terms rather than rippling through lower carries.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[WIDTH], p ^ c[WIDTH-1:0]};
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   q_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] product_r;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     ct_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   q_nxt_s;
  logic               accept_s;
  logic               step_s;
  logic               last_s;

  // One iteration: add M when the multiplier LSB is set, then shift {C,T,Q} right.
  always_comb begin
    sum_s     = cla_add(acc_r, m_r);
    ct_s      = q_r[0] ? sum_s : {1'b0, acc_r};
    acc_nxt_s = ct_s[WIDTH:1];
    q_nxt_s   = {ct_s[0], q_r[WIDTH-1:1]};
  end

  // Next-state and datapath strobes derived from the current state.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          next_state_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          next_state_s = ST_DONE;
          last_s       = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, iteration step and product latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r       <= '0;
      acc_r     <= '0;
      q_r       <= '0;
      cnt_r     <= '0;
      product_r <= '0;
    end else if (accept_s) begin
      m_r   <= a;
      q_r   <= b;
      acc_r <= '0;
      cnt_r <= '0;
    end else if (step_s) begin
      acc_r <= acc_nxt_s;
      q_r   <= q_nxt_s;
      cnt_r <= cnt_r + CNT_ONE;
      if (last_s) begin
        product_r <= {acc_nxt_s, q_nxt_s};
      end
    end
  end

  // Handshake flags come from the state register only.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign product   = product_r;

endmodule

// File: tb/tb_seq_shift_add_mul_8bit.sv
// Directed bench for the sequential shift-and-add multiplier.
module tb_seq_shift_add_mul_8bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks;
  int errors;
  int cyc;

  seq_shift_add_mul_8bit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid after an accept edge; returns edges taken, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // Accept one operand pair, check latency and product, then drain.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_in_ready_run"}, {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_product_kept"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    int lat;
    int prev_acc;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rexp;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);

    // T1, T2
    run_op("t1", 8'd200, 8'd190, 16'h9470);
    run_op("t2_max", 8'd255, 8'd255, 16'hFE01);
    run_op("t2_zero", 8'd0, 8'd123, 16'h0000);

    // T3: backpressure holds product
    a        = 8'd144;
    b        = 8'd89;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("t3_latency", lat, 32'd8);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_hold_product", {16'd0, product}, 32'h0000_3210);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_release_valid", {31'd0, out_valid}, 32'd0);
    check("t3_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("t3_release_busy", {31'd0, busy}, 32'd0);

    // T4: operands offered during RUN are ignored
    a        = 8'd2;
    b        = 8'd223;
    in_valid = 1'b1;
    tick();
    a = 8'd99;
    b = 8'd99;
    wait_done(lat);
    in_valid = 1'b0;
    check("t4_latency", lat, 32'd8);
    check("t4_product", {16'd0, product}, 32'h0000_01BE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_idle", {31'd0, in_ready}, 32'd1);

    // T5: reset during RUN aborts the operation
    a        = 8'd77;
    b        = 8'd33;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_product", {16'd0, product}, 32'd0);
    run_op("t5_after", 8'd80, 8'd255, 16'h4FB0);

    // T6: back-to-back random pairs with consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 100; k++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rexp = {8'd0, ra} * {8'd0, rb};
      a    = ra;
      b    = rb;
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (k > 0) begin
        check("t6_interval", cyc - prev_acc, 32'd10);
      end
      prev_acc = cyc;
      wait_done(lat);
      check("t6_latency", lat, 32'd8);
      check("t6_product", {16'd0, product}, {16'd0, rexp});
      tick();
      check("t6_out_valid_drop", {31'd0, out_valid}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
